// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: requester bus for one data-memory client.
// Fields: req/we/size/addr/wdata from the requester; ack/rdata/err back to it.
// master = requester side, slave = arbiter side.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [63:0]       wdata;
   logic              ack;
   logic [63:0]       rdata;
   logic              err;
   modport master (output req, we, size, addr, wdata, input ack, rdata, err);
   modport slave (input req, we, size, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one 64-bit data memory between two requesters,
// with bounds checking and read-modify-write for byte/half/word stores.
// Ports: clk, reset (sync, active-low), m0/m1 requester buses (slave modport),
//        mem_addr/mem_wdata/mem_write/mem_read out to the memory, mem_rdata back from it.
module data_mem_arbiter #(
   parameter int MEM_BYTES = 64,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_arbiter_if.slave m0,
   data_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [63:0]       mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;
   state_t            state, next;
   logic              owner, rr_last, we_q, err_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q, data_q, lane_mask;
   logic              any_req, gnt, sel_we, oob;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [63:0]       sel_wdata;
   logic [ADDR_W:0]   end_addr;
   logic              rd, wr, resp;

   // m0 wins unless only m1 requests, or both request and m0 went last
   always_comb begin
      any_req   = m0.req | m1.req;
      gnt       = (m0.req && (!m1.req || rr_last)) ? 1'b0 : 1'b1;
      sel_we    = gnt ? m1.we    : m0.we;
      sel_size  = gnt ? m1.size  : m0.size;
      sel_addr  = gnt ? m1.addr  : m0.addr;
      sel_wdata = gnt ? m1.wdata : m0.wdata;
      // one extra bit so addresses near the top cannot wrap into range
      end_addr  = {1'b0, sel_addr} + ((ADDR_W+1)'(1) << sel_size);
      oob       = end_addr > (ADDR_W+1)'(MEM_BYTES);
      lane_mask = size_q == 2'd0 ? 64'h0000_0000_0000_00FF :
                  size_q == 2'd1 ? 64'h0000_0000_0000_FFFF :
                  size_q == 2'd2 ? 64'h0000_0000_FFFF_FFFF : '1;
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:     if (any_req) next = oob ? RESP : !sel_we ? READ : sel_size == 2'd3 ? WRITE : RMW_READ;
         READ:     next = RESP;
         RMW_READ: next = WRITE;
         WRITE:    next = RESP;
         default:  next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner   <= 1'b0;
         rr_last <= 1'b1;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            owner   <= gnt;
            rr_last <= gnt;
            we_q    <= sel_we;
            size_q  <= sel_size;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= oob;
            data_q  <= '0;
         end
         if (state == READ) data_q <= mem_rdata & lane_mask;
         // keep the untouched upper bytes, splice in the store data below them
         if (state == RMW_READ) data_q <= (mem_rdata & ~lane_mask) | (wdata_q & lane_mask);
      end
   end

   // reset gates the strobes immediately so an aborted WRITE never commits
   always_comb begin
      rd        = reset && (state == READ || state == RMW_READ);
      wr        = reset && state == WRITE;
      resp      = reset && state == RESP;
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = (rd || wr) ? addr_q : '0;
      mem_wdata = wr ? (size_q == 2'd3 ? wdata_q : data_q) : '0;
      m0.ack    = resp && !owner;
      m0.err    = resp && !owner && err_q;
      m0.rdata  = (resp && !owner && !we_q) ? data_q : '0;
      m1.ack    = resp && owner;
      m1.err    = resp && owner && err_q;
      m1.rdata  = (resp && owner && !we_q) ? data_q : '0;
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter with a byte-array memory model.
module tb_data_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;
   logic [7:0]  mem [64];
   bit          loaded = 1'b0;
   bit          no_mem = 1'b0;
   int          n_checks = 0, n_fail = 0, n_ack = 0;

   typedef struct {bit port; logic [63:0] rdata; bit err;} rsp_t;
   typedef struct {logic [63:0] addr; logic [63:0] wdata;} wr_t;
   rsp_t rsp_q[$];
   wr_t  wr_q[$];

   data_mem_arbiter_if m0_bus();
   data_mem_arbiter_if m1_bus();

   data_mem_arbiter dut (
      .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always_comb begin
      mem_rdata = '0;
      for (int k = 0; k < 8; k++)
         if (mem_addr < 64'(64 - k)) mem_rdata[8*k +: 8] = mem[int'(mem_addr) + k];
   end

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
         loaded <= 1'b1;
      end else if (mem_write) begin
         for (int k = 0; k < 8; k++)
            if (mem_addr < 64'(64 - k)) mem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_rsp(input bit p, input logic [63:0] rdata, input bit err);
      rsp_t e;
      n_checks++;
      n_ack++;
      if (rsp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_ack: port m%0d rdata %h err %0d, none expected", p, rdata, err);
      end else begin
         e = rsp_q.pop_front();
         if (e.port != p || rdata !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL ack: got m%0d rdata %h err %0d expected m%0d rdata %h err %0d",
                     p, rdata, err, e.port, e.rdata, e.err);
         end
      end
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (m0_bus.ack && m1_bus.ack) chk("both_ack", 64'(m1_bus.ack), 64'd0);
      if (m0_bus.ack) check_rsp(1'b0, m0_bus.rdata, m0_bus.err);
      if (m1_bus.ack) check_rsp(1'b1, m1_bus.rdata, m1_bus.err);
      if (mem_read && mem_write) chk("rd_wr_excl", 64'(mem_write), 64'd0);
      if (no_mem && (mem_read || mem_write)) chk("no_mem_access", {62'd0, mem_read, mem_write}, 64'd0);
      if (mem_write) begin
         n_checks++;
         if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr %h wdata %h, none expected", mem_addr, mem_wdata);
         end else begin
            w = wr_q.pop_front();
            if (mem_addr !== w.addr || mem_wdata !== w.wdata) begin
               n_fail++;
               $display("FAIL write: got addr %h wdata %h expected addr %h wdata %h",
                        mem_addr, mem_wdata, w.addr, w.wdata);
            end
         end
      end
   end

   task automatic drive(input bit p, input bit req, input bit we, input logic [1:0] size,
                        input logic [63:0] addr, input logic [63:0] wdata);
      if (!p) begin
         m0_bus.req = req; m0_bus.we = we; m0_bus.size = size; m0_bus.addr = addr; m0_bus.wdata = wdata;
      end else begin
         m1_bus.req = req; m1_bus.we = we; m1_bus.size = size; m1_bus.addr = addr; m1_bus.wdata = wdata;
      end
   endtask

   // called just after a negedge with the arbiter idle; leaves it idle again
   task automatic txn(input bit p, input bit we, input logic [1:0] size, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [63:0] rexp, input bit eexp, input int lat);
      int n = 0;
      rsp_q.push_back('{port: p, rdata: rexp, err: eexp});
      drive(p, 1'b1, we, size, addr, wdata);
      do begin
         @(negedge clk);
         n++;
      end while (!(p ? m1_bus.ack : m0_bus.ack) && n < 20);
      drive(p, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      chk($sformatf("latency_m%0d_%0h", p, addr), 64'(n), 64'(lat));
      @(negedge clk);
   endtask

   initial begin
      int base, t;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      repeat (3) @(negedge clk);
      chk("rst_m0_ack", 64'(m0_bus.ack), 64'd0);
      chk("rst_m1_ack", 64'(m1_bus.ack), 64'd0);
      chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_m0_rdata", m0_bus.rdata, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // both hold req from reset: grants must alternate starting with m0
      base = n_ack;
      for (int i = 0; i < 2; i++) begin
         rsp_q.push_back('{port: 1'b0, rdata: 64'h0F0E0D0C0B0A0908, err: 1'b0});
         rsp_q.push_back('{port: 1'b1, rdata: 64'h0000000007060504, err: 1'b0});
      end
      drive(1'b0, 1'b1, 1'b0, 2'd3, 64'd8, 64'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd2, 64'd4, 64'd0);
      t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while (n_ack < base + 4 && t < 40);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      chk("fair_acks", 64'(n_ack - base), 64'd4);
      @(negedge clk);

      txn(1'b0, 1'b0, 2'd3, 64'd8, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 2);
      wr_q.push_back('{addr: 64'd3, wdata: 64'h0A090807060504AB});
      txn(1'b1, 1'b1, 2'd0, 64'd3, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0, 3);
      txn(1'b1, 1'b0, 2'd3, 64'd0, 64'd0, 64'h07060504AB020100, 1'b0, 2);

      no_mem = 1'b1;
      txn(1'b0, 1'b1, 2'd3, 64'd60, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1);
      txn(1'b0, 1'b0, 2'd1, 64'd63, 64'd0, 64'd0, 1'b1, 1);
      txn(1'b0, 1'b0, 2'd3, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1, 1);
      no_mem = 1'b0;
      txn(1'b0, 1'b0, 2'd0, 64'd63, 64'd0, 64'h000000000000003F, 1'b0, 2);
      txn(1'b0, 1'b0, 2'd3, 64'd56, 64'd0, 64'h3F3E3D3C3B3A3938, 1'b0, 2);

      wr_q.push_back('{addr: 64'd32, wdata: 64'h2726252423221234});
      txn(1'b0, 1'b1, 2'd1, 64'd32, 64'hAAAAAAAAAAAA1234, 64'd0, 1'b0, 3);
      wr_q.push_back('{addr: 64'd40, wdata: 64'h1122334455667788});
      txn(1'b0, 1'b1, 2'd3, 64'd40, 64'h1122334455667788, 64'd0, 1'b0, 2);
      txn(1'b1, 1'b0, 2'd3, 64'd32, 64'd0, 64'h2726252423221234, 1'b0, 2);
      txn(1'b1, 1'b0, 2'd3, 64'd40, 64'd0, 64'h1122334455667788, 1'b0, 2);

      // reset during RMW_READ drops the word store
      drive(1'b0, 1'b1, 1'b1, 2'd2, 64'd16, 64'h00000000DEADBEEF);
      @(negedge clk);
      chk("abort_rmw_read", {62'd0, mem_read, mem_write}, 64'd2);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      @(negedge clk);
      chk("abort_ack", {62'd0, m0_bus.ack, m1_bus.ack}, 64'd0);
      chk("abort_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      chk("abort_mem_addr", mem_addr, 64'd0);
      chk("abort_mem_wdata", mem_wdata, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b0, 2'd2, 64'd16, 64'd0, 64'h0000000013121110, 1'b0, 2);

      // reset asserted while in WRITE must suppress the strobe before the commit edge
      drive(1'b0, 1'b1, 1'b1, 2'd3, 64'd48, 64'hFFFFFFFFFFFFFFFF);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
      #1;
      chk("abort_write_strobe", 64'(mem_write), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b0, 2'd3, 64'd48, 64'd0, 64'h3736353433323130, 1'b0, 2);
      txn(1'b0, 1'b0, 2'd2, 64'd4, 64'd0, 64'h0000000007060504, 1'b0, 2);

      repeat (3) @(negedge clk);
      chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
